// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: writeback source encodings and default field widths.
package pipe_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 3;
  localparam int SW_DEF = 3;

  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_ALU   = 3'd1,
    SRC_NPC   = 3'd2,
    SRC_SET   = 3'd3,
    SRC_SEXT8 = 3'd4,
    SRC_SLBI  = 3'd5,
    SRC_BTR   = 3'd6
  } reg_src_e;

  // Highest legal writeback source; anything above it is flagged as an error.
  localparam logic [2:0] SRC_MAX = 3'd6;

endpackage

// File: rtl/pipe_field_reg.sv
// One pipeline field: synchronous active-low reset, hold keeps, clr loads zero.
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)       q <= '0;
    else if (!hold) q <= clr ? '0 : d;
  end

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with stall hold, flush/halt squash and sticky error.
// Optional perf counters (stallCnt, bubbleCnt) under EX_MEM_PERF_CNT_EN.
module ex_mem_latch
  import pipe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          exValid,
  input  logic [DW-1:0] exAluOut,
  input  logic [DW-1:0] exSetVal,
  input  logic [DW-1:0] exReg1Data,
  input  logic [DW-1:0] exReg2Data,
  input  logic [DW-1:0] exNextPc,
  input  logic [DW-1:0] exInstr,
  input  logic          exMemEn,
  input  logic          exMemWrt,
  input  logic          exRegWrt,
  input  logic          exHalt,
  input  logic          exErr,
  input  logic [SW-1:0] exRegWrtSrc,
  input  logic [RW-1:0] exWriteReg,
  input  logic          flush,
  input  logic          dMemStall,
  output logic          memValid,
  output logic [DW-1:0] memAluOut,
  output logic [DW-1:0] memSetVal,
  output logic [DW-1:0] memReg1Data,
  output logic [DW-1:0] memReg2Data,
  output logic [DW-1:0] memNextPc,
  output logic [DW-1:0] memInstr,
  output logic          memMemEn,
  output logic          memMemWrt,
  output logic          memRegWrt,
  output logic          memHalt,
  output logic [SW-1:0] memRegWrtSrc,
  output logic [RW-1:0] memWriteReg,
  output logic          haltSeen,
  output logic          err,
`ifdef EX_MEM_PERF_CNT_EN
  output logic [15:0]   stallCnt,
  output logic [15:0]   bubbleCnt,
`endif
  output logic          holdOut
);

  localparam int NDATA = 6;
  localparam int NCTL  = 5;

  logic hold, squash, capture, pendingFlush, srcBad;

  assign hold    = dMemStall;
  assign squash  = flush | pendingFlush | ~exValid | haltSeen;
  assign capture = ~hold & ~squash;
  assign srcBad  = int'(exRegWrtSrc) > int'(SRC_MAX);
  assign holdOut = dMemStall;

  logic [NDATA-1:0][DW-1:0] exData, memData;
  logic [NCTL-1:0]          exCtl, memCtl;

  assign exData = {exInstr, exNextPc, exReg2Data, exReg1Data, exSetVal, exAluOut};
  assign {memInstr, memNextPc, memReg2Data, memReg1Data, memSetVal, memAluOut} = memData;
  assign exCtl  = {exHalt, exRegWrt, exMemWrt, exMemEn, exValid};
  assign {memHalt, memRegWrt, memMemWrt, memMemEn, memValid} = memCtl;

  for (genvar i = 0; i < NDATA; i++) begin : g_data
    pipe_field_reg #(.W(DW)) u_fld (
      .clk(clk), .rst(rst), .hold(hold), .clr(squash), .d(exData[i]), .q(memData[i])
    );
  end

  for (genvar i = 0; i < NCTL; i++) begin : g_ctl
    pipe_field_reg #(.W(1)) u_fld (
      .clk(clk), .rst(rst), .hold(hold), .clr(squash), .d(exCtl[i]), .q(memCtl[i])
    );
  end

  pipe_field_reg #(.W(SW)) u_src (
    .clk(clk), .rst(rst), .hold(hold), .clr(squash), .d(exRegWrtSrc), .q(memRegWrtSrc)
  );

  pipe_field_reg #(.W(RW)) u_wreg (
    .clk(clk), .rst(rst), .hold(hold), .clr(squash), .d(exWriteReg), .q(memWriteReg)
  );

  // A flush arriving during a stall is remembered and applied on release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pendingFlush <= 1'b0;
      haltSeen     <= 1'b0;
      err          <= 1'b0;
    end else if (hold) begin
      if (flush) pendingFlush <= 1'b1;
    end else begin
      pendingFlush <= 1'b0;
      if (capture && exHalt)              haltSeen <= 1'b1;
      if (capture && (exErr || srcBad))   err      <= 1'b1;
    end
  end

`ifdef EX_MEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stallCnt  <= '0;
      bubbleCnt <= '0;
    end else begin
      if (hold && stallCnt != 16'hFFFF)              stallCnt  <= stallCnt + 16'd1;
      if (!hold && squash && bubbleCnt != 16'hFFFF)  bubbleCnt <= bubbleCnt + 16'd1;
    end
  end
`endif

endmodule
